// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ready + rvalid memory
// port and buffers up to two instructions for the pipeline control unit.
module ifetch_unit #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            valid_o,
  output logic [31:0]     instr_o,
  output logic [PC_W-1:0] pc_o,
  output logic [5:0]      op,
  output logic            run,
  output logic [1:0]      state_dbg
);

  // Handshake: a request transfers on a rising edge where imem_req & imem_ready;
  // imem_req/imem_addr hold until then unless a redirect withdraws the request.
  // Responses return in order as single-cycle imem_rvalid pulses, at most one
  // outstanding; the consumer takes the FIFO head on an edge with run=1.

  localparam logic [5:0] OP_NONE = 6'b111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] fetch_addr;

  logic [31:0]     fifo_instr [2];
  logic [PC_W-1:0] fifo_pc    [2];
  logic            rd_ptr;
  logic            wr_ptr;
  logic [1:0]      count;
  logic [1:0]      cnt_next;

  logic            pop;
  logic            push;
  logic            slot_free;
  logic            accept;

  assign run       = ~stall_i;
  assign valid_o   = (count != 2'd0);
  assign instr_o   = valid_o ? fifo_instr[rd_ptr] : 32'h0;
  assign pc_o      = valid_o ? fifo_pc[rd_ptr] : '0;
  assign op        = (valid_o && !redirect_valid) ? instr_o[31:26] : OP_NONE;
  assign imem_addr = pc;
  assign state_dbg = state;

  assign pop       = valid_o & run & ~redirect_valid;
  assign push      = (state == WAIT) & imem_rvalid & ~redirect_valid;
  assign cnt_next  = count + {1'b0, push} - {1'b0, pop};
  assign slot_free = (cnt_next < 2'd2);
  assign accept    = (state == REQ) & imem_ready;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (redirect_valid || slot_free) state_n = REQ;
      end
      REQ: begin
        // An accepted request under redirect still owes a response to drain.
        if (imem_ready) state_n = redirect_valid ? DROP : WAIT;
      end
      WAIT: begin
        if (imem_rvalid) state_n = (redirect_valid || slot_free) ? REQ : IDLE;
        else if (redirect_valid) state_n = DROP;
      end
      DROP: begin
        if (imem_rvalid) state_n = REQ;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      imem_req   <= 1'b0;
      pc         <= RESET_PC;
      fetch_addr <= '0;
      count      <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
    end else begin
      state    <= state_n;
      imem_req <= (state_n == REQ);
      if (redirect_valid) pc <= redirect_pc;
      else if (accept) pc <= pc + PC_W'(4);
      if (accept) fetch_addr <= pc;
      if (redirect_valid) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        count <= cnt_next;
        if (pop) rd_ptr <= ~rd_ptr;
        if (push) wr_ptr <= ~wr_ptr;
      end
    end
  end

  // Storage needs no reset: entries are only visible once counted in.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= fetch_addr;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && (count == 2'd2)));

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed timing scenarios plus randomized memory
// latency, stalls and redirects checked against a program-order fetch model.
module tb_ifetch_unit;

  localparam int unsigned PC_W     = 32;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [5:0]  NONE     = 6'b111111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [5:0]  op;
  logic        run;
  logic [1:0]  state_dbg;

  ifetch_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o), .op(op), .run(run),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];        // PCs the FIFO should hold, head first
  logic [31:0] prog_pc;         // next PC the consumer should see
  logic [31:0] fetch_pc;        // next address the unit should request
  logic [31:0] resp_addr;
  logic        busy = 1'b0;     // memory holds an accepted request
  logic        live = 1'b0;     // that request's data is still wanted
  logic        hold = 1'b0;     // last cycle had an unaccepted request
  logic        rand_mem = 1'b0;
  logic        force_stale = 1'b0;
  int          lat = 0;
  int          dir_lat = 1;
  int          starve = 0;

  logic        obs_req, obs_valid, obs_run;
  logic [5:0]  obs_op;
  logic [31:0] obs_addr, obs_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h8C01_0000;
      32'h4:   return 32'hAC01_0004;
      32'h8:   return 32'h0000_0020;
      default: return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    prog_pc  = RESET_PC;
    fetch_pc = RESET_PC;
    busy     = 1'b0;
    live     = 1'b0;
    hold     = 1'b0;
    starve   = 0;
  endtask

  // Called on a negedge; mid=1 asserts reset part-way into the low phase.
  task automatic do_reset(input logic mid);
    if (mid) #2;
    rst = 1'b1; stall_i = 1'b1; redirect_valid = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    #1;
    check("rst_imem_req", imem_req, 0);
    check("rst_valid_o", valid_o, 0);
    check("rst_instr_o", instr_o, 0);
    check("rst_pc_o", pc_o, 0);
    check("rst_op", op, NONE);
    check("rst_run_stalled", run, 0);
    stall_i = 1'b0;
    #1;
    check("rst_run", run, 1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- driver + checker, one clock cycle ----------------
  task automatic cycle(input logic s, input logic r, input logic [31:0] rpc);
    logic        acc, resp, pop;
    logic [31:0] acc_addr, w;
    stall_i        = s;
    redirect_valid = r;
    redirect_pc    = rpc;
    resp           = busy && (lat == 1);
    imem_rvalid    = resp || force_stale;
    imem_rdata     = resp ? mem_word(resp_addr) : (force_stale ? 32'hFC00_DEAD : 32'h0);
    force_stale    = 1'b0;
    imem_ready     = !busy && (rand_mem ? ($urandom_range(0, 3) != 0) : 1'b1);
    #1;
    obs_req = imem_req; obs_addr = imem_addr; obs_valid = valid_o;
    obs_pc = pc_o; obs_op = op; obs_run = run;

    check("run", run, !s);
    check("valid_o", valid_o, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      w = mem_word(exp_q[0]);
      check("pc_o", pc_o, exp_q[0]);
      check("instr_o", instr_o, w);
      check("op", op, r ? NONE : w[31:26]);
    end else begin
      check("pc_o_empty", pc_o, 0);
      check("instr_o_empty", instr_o, 0);
      check("op_empty", op, NONE);
    end
    if (imem_req) begin
      check("imem_addr", imem_addr, fetch_pc);
      check("one_outstanding", busy, 0);
    end
    if (hold) check("req_hold", imem_req, 1);
    if (exp_q.size() == 2) check("full_parks", imem_req, 0);

    // Advance the reference model across the coming rising edge.
    acc      = imem_req && imem_ready;
    acc_addr = fetch_pc;
    pop      = (exp_q.size() != 0) && !s && !r;
    if (pop) begin
      check("pop_order", pc_o, prog_pc);
      prog_pc = prog_pc + 32'd4;
      void'(exp_q.pop_front());
      starve = 0;
    end else if (!s) begin
      starve++;
      if (starve > 100) begin
        check("starve_cycles", starve, 0);
        starve = 0;
      end
    end
    if (busy && lat > 1) lat--;
    if (r) begin
      exp_q.delete();
      live     = 1'b0;
      prog_pc  = rpc;
      fetch_pc = rpc;
    end
    if (resp) begin
      busy = 1'b0;
      if (live) exp_q.push_back(resp_addr);
    end
    if (acc) begin
      busy      = 1'b1;
      resp_addr = acc_addr;
      live      = !r;
      lat       = rand_mem ? int'($urandom_range(1, 3)) : dir_lat;
      if (!r) fetch_pc = fetch_pc + 32'd4;
    end
    hold = imem_req && !imem_ready;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] line_op  [8];
    logic       line_req [8];
    int         stall_left;
    logic       s, r;
    logic [31:0] rpc;

    line_op  = '{NONE, NONE, NONE, 6'b100011, NONE, 6'b101011, NONE, 6'b000000};
    line_req = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    @(negedge clk);

    // Straight-line fetch with 1-cycle memory.
    rand_mem = 1'b0; dir_lat = 1;
    do_reset(1'b0);
    for (int c = 0; c < 8; c++) begin
      cycle(1'b0, 1'b0, 32'h0);
      check($sformatf("line_op_c%0d", c), obs_op, line_op[c]);
      check($sformatf("line_req_c%0d", c), obs_req, line_req[c]);
      if (obs_req) check($sformatf("line_addr_c%0d", c), obs_addr, 32'(2 * (c - 1)));
    end

    // Stall fill: FIFO fills, fetch parks, then two back-to-back pops.
    do_reset(1'b0);
    for (int c = 0; c < 3; c++) cycle(1'b0, 1'b0, 32'h0);
    for (int c = 3; c < 9; c++) begin
      cycle(1'b1, 1'b0, 32'h0);
      check("stall_op_hold", obs_op, 6'b100011);
    end
    check("stall_parked_req", obs_req, 0);
    check("stall_run", obs_run, 0);
    check("stall_valid", obs_valid, 1);
    cycle(1'b0, 1'b0, 32'h0);
    check("release_op0", obs_op, 6'b100011);
    cycle(1'b0, 1'b0, 32'h0);
    check("release_op1", obs_op, 6'b101011);

    // Redirect while waiting on 0x8.
    do_reset(1'b0);
    for (int c = 0; c < 6; c++) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h100);
    check("rdw_op_c6", obs_op, NONE);
    cycle(1'b0, 1'b0, 32'h0);
    check("rdw_req_c7", obs_req, 1);
    check("rdw_addr_c7", obs_addr, 32'h100);
    check("rdw_op_c7", obs_op, NONE);
    cycle(1'b0, 1'b0, 32'h0);
    check("rdw_op_c8", obs_op, NONE);
    cycle(1'b0, 1'b0, 32'h0);
    check("rdw_valid_c9", obs_valid, 1);
    check("rdw_pc_c9", obs_pc, 32'h100);

    // Redirect coinciding with acceptance of the 0x4 request.
    do_reset(1'b0);
    for (int c = 0; c < 3; c++) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h200);
    check("rda_req_c3", obs_req, 1);
    check("rda_op_c3", obs_op, NONE);
    cycle(1'b0, 1'b0, 32'h0);
    check("rda_drop_req_c4", obs_req, 0);
    check("rda_valid_c4", obs_valid, 0);
    cycle(1'b0, 1'b0, 32'h0);
    check("rda_req_c5", obs_req, 1);
    check("rda_addr_c5", obs_addr, 32'h200);
    cycle(1'b0, 1'b0, 32'h0);
    check("rda_valid_c6", obs_valid, 0);
    cycle(1'b0, 1'b0, 32'h0);
    check("rda_pc_c7", obs_pc, 32'h200);

    // Reset while a request is outstanding, stale response afterwards.
    do_reset(1'b0);
    dir_lat = 3;
    for (int c = 0; c < 3; c++) cycle(1'b0, 1'b0, 32'h0);
    do_reset(1'b1);
    dir_lat = 1;
    force_stale = 1'b1;
    cycle(1'b0, 1'b0, 32'h0);
    check("mid_rst_req_c0", obs_req, 0);
    check("mid_rst_op_c0", obs_op, NONE);
    cycle(1'b0, 1'b0, 32'h0);
    check("mid_rst_req_c1", obs_req, 1);
    check("mid_rst_addr_c1", obs_addr, RESET_PC);
    check("mid_rst_valid_c1", obs_valid, 0);
    cycle(1'b0, 1'b0, 32'h0);
    check("mid_rst_valid_c2", obs_valid, 0);
    cycle(1'b0, 1'b0, 32'h0);
    check("mid_rst_pc_c3", obs_pc, RESET_PC);

    // PC wrap-around.
    do_reset(1'b0);
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 32'h0);
    check("wrap_addr_c1", obs_addr, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    check("wrap_addr_c3", obs_addr, 32'h0);
    check("wrap_pc_c3", obs_pc, 32'hFFFF_FFFC);

    // Randomized memory latency, ready, stalls and redirects.
    rand_mem = 1'b1;
    do_reset(1'b0);
    stall_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset(1'b1);
      if (stall_left == 0 && $urandom_range(0, 15) == 0) stall_left = int'($urandom_range(1, 8));
      s = (stall_left != 0) || ($urandom_range(0, 7) == 0);
      if (stall_left != 0) stall_left--;
      r = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      cycle(s, r, rpc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage of the 5-stage pipelined CPU. It owns the PC, fetches instruction words from instruction memory over a request/response handshake, and buffers them in a 2-entry FIFO. It presents the head instruction's opcode (`op`) and the pipeline advance enable (`run`) to the downstream pipeline control unit. When no instruction is available, `op` carries the bubble code 6'b111111 (NONE).

## Interface
- `PC_W`, 32, PC and address width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `stall_i`  in  1  hazard stall from downstream; freezes consumption
- `redirect_valid`  in  1  branch/jump taken; flush and refetch
- `redirect_pc`  in  PC_W  target address, sampled when `redirect_valid`=1
- `imem_req`  out  1  fetch request, registered
- `imem_addr`  out  PC_W  fetch address, valid while `imem_req`=1
- `imem_ready`  in  1  memory accepts request this cycle
- `imem_rvalid`  in  1  read data returned, in order, ≥1 cycle after acceptance
- `imem_rdata`  in  32  instruction word
- `valid_o`  out  1  FIFO head holds an instruction
- `instr_o`  out  32  head instruction; 32'h0 when `valid_o`=0
- `pc_o`  out  PC_W  PC of head instruction; 0 when `valid_o`=0
- `op`  out  6  `instr_o[31:26]` when `valid_o`=1 and `redirect_valid`=0, else 6'b111111
- `run`  out  1  pipeline advance = `~stall_i`

## Operation
- **FSM states:** IDLE, REQ, WAIT, DROP. At most one request is outstanding. `imem_req` is 1 only in REQ, with `imem_addr` = `pc`.
- **Reset values:** state IDLE, `pc`=RESET_PC, FIFO empty. Outputs: `imem_req`=0, `valid_o`=0, `instr_o`=0, `pc_o`=0, `op`=6'b111111. `run` follows `~stall_i` combinationally, including during reset.
- **pop** = `valid_o & run & ~redirect_valid`.
- **push** = state WAIT & `imem_rvalid` & ~`redirect_valid`. It writes {`imem_rdata`, address} to the FIFO tail.
- **cnt_next** = count + push − pop (range 0..2). Push into a full FIFO cannot occur by construction; a request is only issued when a slot is guaranteed.
- **IDLE:** go to REQ if cnt_next < 2; ignore `imem_rvalid`.
- **REQ:** hold `imem_req` and `imem_addr` stable until `imem_ready`. On `imem_ready`: `pc` <= `pc`+4 (wraps modulo 2^PC_W), go to WAIT.
- **WAIT:** on `imem_rvalid`, push, then go to REQ if cnt_next < 2, else IDLE.
- **DROP:** on `imem_rvalid`, discard the data and go to REQ.
- **Redirect** (`redirect_valid`=1) has priority over everything:
  - FIFO cleared, pop and push suppressed, `pc` <= `redirect_pc`.
  - Next state depends on the current state:
    - IDLE → REQ.
    - REQ with `imem_ready`=1 (the request was accepted) → DROP.
    - REQ with `imem_ready`=0 → REQ; the request is withdrawn and reissued next cycle at the new address. Memory must tolerate withdrawal.
    - WAIT without `imem_rvalid` → DROP.
    - WAIT with `imem_rvalid` → REQ (the data is discarded).
    - DROP without `imem_rvalid` → DROP.
    - DROP with `imem_rvalid` → REQ.
- **Stall:** with `stall_i`=1, no pop occurs and `op`/`instr_o`/`pc_o` hold. Fetch continues until the FIFO holds 2 entries, then the FSM parks in IDLE.

## Timing
- **Request to `op`:** with 1-cycle memory (`imem_ready`=1, `imem_rvalid` the cycle after acceptance), a request accepted in cycle t gives data in cycle t+1 and `valid_o`/`op` in cycle t+2.
- **Throughput:** 1 instruction per 2 cycles at 1-cycle memory latency.
- **After reset release:** IDLE (cycle 0), REQ at RESET_PC (cycle 1), WAIT (cycle 2), first `op` valid in cycle 3.
- **Consumption:** the downstream stage samples `op` on the edge where `run`=1. The FIFO head advances on that same edge.
- **Redirect to fetch:** `redirect_valid` in cycle r gives `imem_req` at `redirect_pc` in cycle r+1, or after the stale response arrives if in DROP.
- **Reset mid-transaction:** state returns to IDLE immediately. A late `imem_rvalid` after reset is ignored.

## Test plan
- **Straight-line fetch:** reset, 1-cycle memory, `stall_i`=0, memory holds opcodes 0x23,0x2B,0x00 at 0x0/0x4/0x8 -> `imem_addr` sequence 0x0,0x4,0x8. `op` shows 6'b100011 in cycle 3, then 6'b101011, then 6'b000000; 6'b111111 between them.
- **Stall fill:** hold `stall_i`=1 from cycle 3 -> FIFO reaches 2 entries, `imem_req`=0 (IDLE), `op` stable at the 0x0 opcode, `run`=0. Release -> the 0x0 and 0x4 opcodes are consumed on consecutive edges.
- **Redirect in WAIT:** `redirect_valid`=1, `redirect_pc`=0x100 while waiting on 0x8 -> 0x8 data dropped, next `imem_addr`=0x100. `op`=6'b111111 until the 0x100 instruction arrives; `pc_o`=0x100.
- **Redirect with accept:** `redirect_valid` coincides with `imem_ready` for 0x4 -> DROP state, the stale 0x4 response is not pushed, next request at `redirect_pc`.
- **Reset mid-WAIT:** assert `rst` while a request is outstanding, then pulse `imem_rvalid` after release -> `valid_o`=0, `op`=6'b111111, first request at RESET_PC, stale data never appears.
- **Wrap-around:** `redirect_pc`=32'hFFFF_FFFC -> the request following it has `imem_addr`=32'h0000_0000.
